// File: rtl/johnson_decoder_monitor.sv
// Checks and decodes a sampled Johnson-coded bus, tracks the expected successor,
// declares lock after a run of good steps and counts sequence breaks while locked.
module johnson_decoder_monitor #(
    parameter int WIDTH      = 5,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8,
    localparam int IDX_W     = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     code_in,
    input  logic                 err_clr,
    output logic [IDX_W-1:0]     index,
    output logic                 index_valid,
    output logic                 locked,
    output logic                 seq_error,
    output logic [ERR_CNT_W-1:0] err_count
);

    // state    | meaning
    // UNLOCKED | no legal history, waiting for a legal code
    // ACQUIRE  | counting consecutive legal successors toward lock
    // LOCKED   | sequence tracked; any deviation is a seq_error
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam int NUM_STATES = 2 * WIDTH;
    localparam int CNT_W      = $clog2(LOCK_COUNT + 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     lock_cnt, lock_cnt_nxt;
    logic                 legal;
    logic [IDX_W-1:0]     dec_index;
    logic [IDX_W-1:0]     succ_index;
    logic                 is_succ;
    logic                 brk;
    logic [ERR_CNT_W-1:0] err_nxt;

    always_comb begin
        int trans;
        int ones;
        trans = 0;
        ones  = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (code_in[i] != code_in[i+1]) trans++;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (code_in[i]) ones++;
        end
        legal     = (trans <= 1);
        dec_index = code_in[WIDTH-1] ? IDX_W'(NUM_STATES - ones) : IDX_W'(ones);
    end

    // index still holds the previous sample, so it is the base for the successor
    assign succ_index = (index == IDX_W'(NUM_STATES - 1)) ? '0 : index + 1'b1;
    assign is_succ    = legal && index_valid && (dec_index == succ_index);

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        brk          = 1'b0;
        if (enable) begin
            case (state)
                UNLOCKED: begin
                    if (legal) begin
                        state_nxt    = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
                        lock_cnt_nxt = CNT_W'(1);
                    end else begin
                        lock_cnt_nxt = '0;
                    end
                end
                ACQUIRE: begin
                    if (!legal) begin
                        state_nxt    = UNLOCKED;
                        lock_cnt_nxt = '0;
                    end else if (is_succ) begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                        if (int'(lock_cnt) + 1 >= LOCK_COUNT) state_nxt = LOCKED;
                    end else begin
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (!is_succ) begin
                        brk = 1'b1;
                        if (legal) begin
                            state_nxt    = ACQUIRE;
                            lock_cnt_nxt = CNT_W'(1);
                        end else begin
                            state_nxt    = UNLOCKED;
                            lock_cnt_nxt = '0;
                        end
                    end
                end
                default: begin
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    // clear first, then the increment, so a clear coinciding with a break leaves 1
    always_comb begin
        err_nxt = err_clr ? '0 : err_count;
        if (brk && (err_nxt != {ERR_CNT_W{1'b1}})) err_nxt = err_nxt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= UNLOCKED;
            lock_cnt    <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            seq_error   <= 1'b0;
            err_count   <= '0;
        end else begin
            state     <= state_nxt;
            lock_cnt  <= lock_cnt_nxt;
            err_count <= err_nxt;
            seq_error <= brk;
            if (enable) begin
                index       <= legal ? dec_index : '0;
                index_valid <= legal;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Bench for johnson_decoder_monitor: directed table, corner sequences and random
// stimulus against a table-lookup reference model; two instances share stimulus.
module tb_johnson_decoder_monitor;

    localparam int WIDTH = 5;
    localparam int NST   = 2 * WIDTH;
    localparam int LC    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       err_clr = 1'b0;
    logic [4:0] code_in = 5'd0;

    logic [3:0] index_a, index_b;
    logic       valid_a, valid_b, locked_a, locked_b, seq_error_a, seq_error_b;
    logic [7:0] err_count_a;
    logic [1:0] err_count_b;

    int    errors = 0;
    int    checks = 0;
    string tag = "init";

    int m_idx, m_streak, m_cnt_a, m_cnt_b;
    bit m_valid, m_locked, m_err;
    logic [4:0] legal_code [NST];

    typedef struct {
        logic [4:0] code;
        int         idx;
        bit         valid;
        bit         lck;
    } vec_t;
    vec_t tbl [11];

    johnson_decoder_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .code_in(code_in), .err_clr(err_clr),
        .index(index_a), .index_valid(valid_a), .locked(locked_a),
        .seq_error(seq_error_a), .err_count(err_count_a)
    );

    johnson_decoder_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(LC), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .code_in(code_in), .err_clr(err_clr),
        .index(index_b), .index_valid(valid_b), .locked(locked_b),
        .seq_error(seq_error_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    function automatic int find_code(logic [4:0] c);
        for (int k = 0; k < NST; k++) if (legal_code[k] == c) return k;
        return -1;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic model(bit rn, bit en, logic [4:0] code, bit clr);
        int  k;
        bit  succ;
        bit  brk;
        brk = 0;
        if (!rn) begin
            m_idx = 0; m_valid = 0; m_locked = 0; m_streak = 0;
            m_err = 0; m_cnt_a = 0; m_cnt_b = 0;
            return;
        end
        if (en) begin
            k = find_code(code);
            if (k < 0) begin
                if (m_locked) brk = 1;
                m_locked = 0; m_streak = 0; m_idx = 0; m_valid = 0;
            end else begin
                succ = m_valid && (k == (m_idx + 1) % NST);
                if (m_locked) begin
                    if (!succ) begin
                        brk = 1; m_locked = 0; m_streak = 1;
                    end
                end else begin
                    m_streak = succ ? m_streak + 1 : 1;
                    if (m_streak >= LC) m_locked = 1;
                end
                m_idx = k; m_valid = 1;
            end
        end
        m_err = brk;
        if (clr) begin m_cnt_a = 0; m_cnt_b = 0; end
        if (brk) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
    endtask

    task automatic step(bit rn, bit en, logic [4:0] code, bit clr);
        rst_n = rn; enable = en; code_in = code; err_clr = clr;
        @(posedge clk);
        model(rn, en, code, clr);
        #1;
        check("index_a", int'(index_a), m_idx);
        check("index_b", int'(index_b), m_idx);
        check("valid", int'(valid_a), int'(m_valid));
        check("locked", int'(locked_a), int'(m_locked));
        check("locked_b", int'(locked_b), int'(m_locked));
        check("seq_error", int'(seq_error_a), int'(m_err));
        check("seq_error_b", int'(seq_error_b), int'(m_err));
        check("err_count_a", int'(err_count_a), m_cnt_a);
        check("err_count_b", int'(err_count_b), m_cnt_b);
    endtask

    task automatic go(logic [4:0] code);
        step(1, 1, code, 0);
    endtask

    task automatic next_succ();
        go(legal_code[(m_idx + 1) % NST]);
    endtask

    initial begin
        logic [4:0] c;
        int r;

        for (int k = 0; k < NST; k++) begin
            if (k < WIDTH) legal_code[k] = 5'((1 << k) - 1);
            else           legal_code[k] = 5'(((1 << WIDTH) - 1) ^ ((1 << (k - WIDTH)) - 1));
        end
        tbl[0]  = '{5'b00000, 0, 1, 0};
        tbl[1]  = '{5'b00001, 1, 1, 0};
        tbl[2]  = '{5'b00011, 2, 1, 1};
        tbl[3]  = '{5'b00111, 3, 1, 1};
        tbl[4]  = '{5'b01111, 4, 1, 1};
        tbl[5]  = '{5'b11111, 5, 1, 1};
        tbl[6]  = '{5'b11110, 6, 1, 1};
        tbl[7]  = '{5'b11100, 7, 1, 1};
        tbl[8]  = '{5'b11000, 8, 1, 1};
        tbl[9]  = '{5'b10000, 9, 1, 1};
        tbl[10] = '{5'b00000, 0, 1, 1};

        tag = "reset";
        step(0, 1, 5'b10101, 0);
        step(0, 1, 5'b10101, 0);
        check("rst_index", int'(index_a), 0);
        check("rst_locked", int'(locked_a), 0);
        check("rst_count", int'(err_count_a), 0);
        for (int i = 0; i < 3; i++) step(1, 0, 5'b00111, 0);
        check("hold_valid", int'(valid_a), 0);

        tag = "lock_wrap";
        foreach (tbl[i]) begin
            go(tbl[i].code);
            check("tbl_index", int'(index_a), tbl[i].idx);
            check("tbl_valid", int'(valid_a), int'(tbl[i].valid));
            check("tbl_locked", int'(locked_a), int'(tbl[i].lck));
            check("tbl_seq_error", int'(seq_error_a), 0);
        end
        check("wrap_count", int'(err_count_a), 0);

        tag = "illegal_locked";
        go(5'b00001); go(5'b00011); go(5'b00111); go(5'b01111);
        go(5'b00101);
        check("ill_seq_error", int'(seq_error_a), 1);
        check("ill_count", int'(err_count_a), 1);
        check("ill_valid", int'(valid_a), 0);
        check("ill_locked", int'(locked_a), 0);
        go(5'b11111); go(5'b11110);
        check("ill_not_yet", int'(locked_a), 0);
        go(5'b11100);
        check("ill_relock", int'(locked_a), 1);

        tag = "skip_repeat";
        go(5'b00000); go(5'b00001); go(5'b00011);
        check("sk_locked", int'(locked_a), 1);
        go(5'b01111);
        check("sk_seq_error", int'(seq_error_a), 1);
        go(5'b11111); go(5'b11110);
        check("sk_relock", int'(locked_a), 1);
        go(5'b11110);
        check("rep_seq_error", int'(seq_error_a), 1);
        check("rep_count_a", int'(err_count_a), 4);
        check("rep_count_b", int'(err_count_b), 3);

        tag = "enable_gap";
        for (int pass = 0; pass < 2; pass++) begin
            step(0, 1, 5'b00000, 0);
            go(5'b00111); go(5'b01111); go(5'b11111); go(5'b11110);
            for (int i = 0; i < 5; i++) step(1, 0, 5'($urandom), 0);
            check("gap_index", int'(index_a), 6);
            check("gap_locked", int'(locked_a), 1);
            check("gap_seq_error", int'(seq_error_a), 0);
            if (pass == 0) begin
                go(5'b11000);
                check("gap_skip_index", int'(index_a), 8);
                check("gap_skip_err", int'(seq_error_a), 1);
            end else begin
                go(5'b11100);
                check("gap_ok_index", int'(index_a), 7);
                check("gap_ok_locked", int'(locked_a), 1);
            end
        end

        tag = "saturate";
        step(0, 1, 5'b00000, 0);
        go(5'b00000); go(5'b00001); go(5'b00011);
        for (int i = 0; i < 5; i++) begin
            go(legal_code[m_idx]);
            next_succ(); next_succ();
        end
        check("sat_count_a", int'(err_count_a), 5);
        check("sat_count_b", int'(err_count_b), 3);
        step(1, 0, 5'b00000, 1);
        check("clr_count_b", int'(err_count_b), 0);
        step(1, 1, legal_code[m_idx], 1);
        check("clr_brk_count", int'(err_count_b), 1);
        next_succ(); next_succ();
        step(0, 1, legal_code[(m_idx + 1) % NST], 0);
        check("mid_rst_index", int'(index_a), 0);
        check("mid_rst_count", int'(err_count_a), 0);
        check("mid_rst_locked", int'(locked_a), 0);

        tag = "random";
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70 && m_valid) c = legal_code[(m_idx + 1) % NST];
            else if (r < 88)       c = legal_code[$urandom_range(0, NST - 1)];
            else                   c = 5'($urandom);
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, c,
                 $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
